// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM round-robin arbiter.
// Holds the FSM state encoding, the out-of-range read pattern and the default DRAM depth.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [15:0] ERR_DATA          = 16'hDEAD;
    localparam int          DEFAULT_MEM_DEPTH = 1025;

    // Next requester index after idx, wrapping back to 0 after n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at or above
// ptr, wrapping from NUM_CORES-1 back to 0, plus a flag saying whether any bit was set.
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     winner,
    output logic                 found
);

    int cand;

    // Walk from the farthest offset down to ptr so the nearest set bit is written last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            if (req[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter giving NUM_CORES requesters single-access turns on a shared DRAM port.
// Optional feature: define DRAM_ARB_BOUNDS_CHECK_EN to block and flag accesses at or above MEM_DEPTH.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic                        err,
    output logic                        busy,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cur;
    logic               lat_we;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [ADDR_W-1:0]  addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]  wdata_arr [NUM_CORES];
    logic [ADDR_W-1:0]  pick_addr;
    logic               pick_blocked;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .found  (pick_found)
    );

    assign pick_addr = addr_arr[pick_idx];

`ifdef DRAM_ARB_BOUNDS_CHECK_EN
    logic lat_oob;
    logic err_q;

    assign pick_blocked = (int'(pick_addr) >= MEM_DEPTH);
    assign err          = err_q;
`else
    assign pick_blocked = 1'b0;
    assign err          = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_found) next_state = ACCESS;
            ACCESS:  next_state = CAPTURE;
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // mem_we is a one-cycle pulse covering ACCESS only; address and data stay parked afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cur       <= '0;
            lat_we    <= 1'b0;
            ack       <= '0;
            rdata     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef DRAM_ARB_BOUNDS_CHECK_EN
            lat_oob   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            ack    <= '0;
            mem_we <= 1'b0;
`ifdef DRAM_ARB_BOUNDS_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cur       <= pick_idx;
                        lat_we    <= we[pick_idx];
                        mem_we    <= we[pick_idx] & ~pick_blocked;
                        mem_addr  <= pick_addr;
                        mem_wdata <= wdata_arr[pick_idx];
`ifdef DRAM_ARB_BOUNDS_CHECK_EN
                        lat_oob   <= pick_blocked;
`endif
                    end
                end
                CAPTURE: begin
                    ack[cur] <= 1'b1;
                    ptr      <= IDX_W'(wrap_inc(int'(cur), NUM_CORES));
`ifdef DRAM_ARB_BOUNDS_CHECK_EN
                    if (lat_oob) begin
                        rdata <= DATA_W'(ERR_DATA);
                        err_q <= 1'b1;
                    end else if (!lat_we) begin
                        rdata <= mem_rdata;
                    end
`else
                    if (!lat_we) begin
                        rdata <= mem_rdata;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus a randomized
// multi-core phase checked against a round-robin/shadow-memory reference model.
module tb_dram_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    int testsRun    = 0;
    int testsFailed = 0;
    int memWeCount  = 0;
    int errCount    = 0;

    logic [15:0] dram [0:1024];
    logic        memLoad;

    dram_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_DEPTH (1025)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] initVal(input int i);
        if (i == 5) return 16'd23;
        if (i == 7) return 16'd143;
        return 16'(i) ^ 16'hA5A5;
    endfunction

    // Behavioural DRAM: synchronous write, read data registered one edge after the address.
    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 1025; i++) dram[i] <= initVal(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we && mem_addr < 16'd1025) dram[11'(mem_addr)] <= mem_wdata;
            mem_rdata <= (mem_addr < 16'd1025) ? dram[11'(mem_addr)] : 16'h0;
        end
    end

    always @(posedge clk) begin
        if (mem_we) memWeCount++;
        if (err) errCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int core, input logic w, input logic [15:0] a, input logic [15:0] d);
        we[core]             = w;
        addr[core*AW +: AW]  = a;
        wdata[core*DW +: DW] = d;
        req[core]            = 1'b1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic waitAck(output logic [N-1:0] a, output int cycles);
        a      = '0;
        cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                a      = ack;
                cycles = k;
                return;
            end
        end
        checkOutput("ackTimeout", 32'd1, 32'd0);
    endtask

    function automatic int rrExpect(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    logic [N-1:0] a;
    int           lat;
    int           weBefore;
    logic [N-1:0] ackSeen;

    logic [N-1:0] hist [4];
    logic [15:0]  refMem [0:1024];
    int           remaining [N];
    int           cool [N];
    logic         pendWe [N];
    logic [15:0]  pendAddr [N];
    logic [15:0]  pendData [N];
    int           modelPtr;
    logic [15:0]  modelRdata;
    int           lastAckCyc;
    int           writesExp;
    int           expW;
    int           idleRun;

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        memLoad = 1'b1;
        repeat (2) @(posedge clk);
        #1 memLoad = 1'b0;

        // Reset state
        checkOutput("rstAck", 32'(ack), 32'd0);
        checkOutput("rstRdata", 32'(rdata), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstMemWe", 32'(mem_we), 32'd0);
        checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
        checkOutput("rstMemWdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleMemWe", 32'(memWeCount), 32'd0);

        // Single read by core 2
        weBefore = memWeCount;
        applyStimulus(2, 1'b0, 16'd5, 16'h0);
        waitAck(a, lat);
        req[2] = 1'b0;
        checkOutput("rdAck", 32'(a), 32'b0100);
        checkOutput("rdLatency", 32'(lat), 32'd3);
        checkOutput("rdData", 32'(rdata), 32'd23);
        @(posedge clk);
        #1;
        checkOutput("rdAckPulse", 32'(ack), 32'd0);
        checkOutput("rdNoWrite", 32'(memWeCount - weBefore), 32'd0);

        // Write then read by core 0
        weBefore = memWeCount;
        applyStimulus(0, 1'b1, 16'd100, 16'h1234);
        waitAck(a, lat);
        checkOutput("wrAck", 32'(a), 32'b0001);
        checkOutput("wrRdataHeld", 32'(rdata), 32'd23);
        applyStimulus(0, 1'b0, 16'd100, 16'h0);
        waitAck(a, lat);
        req[0] = 1'b0;
        checkOutput("wrRdAck", 32'(a), 32'b0001);
        checkOutput("wrRdData", 32'(rdata), 32'h1234);
        checkOutput("wrWeCycles", 32'(memWeCount - weBefore), 32'd1);
        checkOutput("wrParkedAddr", 32'(mem_addr), 32'd100);

        // Fairness with all requests held
        doReset();
        for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 16'(16 + i), 16'h0);
        for (int k = 0; k < 5; k++) begin
            waitAck(a, lat);
            checkOutput($sformatf("fairAck%0d", k), 32'(a), 32'(1 << (k % N)));
            if (k > 0) checkOutput($sformatf("fairGap%0d", k), 32'(lat), 32'd4);
        end
        req = '0;
        repeat (4) @(posedge clk);

        // Reset in the middle of a write access
        doReset();
        applyStimulus(1, 1'b1, 16'd7, 16'h5555);
        @(posedge clk);
        #1;
        checkOutput("midWeBefore", 32'(mem_we), 32'd1);
        rst_n  = 1'b0;
        req[1] = 1'b0;
        #1;
        checkOutput("midWeAsync", 32'(mem_we), 32'd0);
        checkOutput("midBusy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ackSeen = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1 ackSeen |= ack;
        end
        checkOutput("midNoAck", 32'(ackSeen), 32'd0);
        applyStimulus(3, 1'b0, 16'd7, 16'h0);
        applyStimulus(0, 1'b0, 16'd7, 16'h0);
        waitAck(a, lat);
        req[0] = 1'b0;
        checkOutput("midPtrRestart", 32'(a), 32'b0001);
        checkOutput("midData0", 32'(rdata), 32'd143);
        waitAck(a, lat);
        req[3] = 1'b0;
        checkOutput("midNext", 32'(a), 32'b1000);
        checkOutput("midData3", 32'(rdata), 32'd143);
        repeat (3) @(posedge clk);

        // Randomized multi-core traffic against a round-robin and shadow-memory model
        doReset();
        for (int i = 0; i < 1025; i++) refMem[i] = initVal(i);
        for (int i = 0; i < N; i++) begin
            remaining[i] = 12;
            cool[i]      = $urandom_range(0, 3);
        end
        for (int i = 0; i < 4; i++) hist[i] = '0;
        modelPtr   = 0;
        modelRdata = 16'h0;
        lastAckCyc = -100;
        writesExp  = 0;
        weBefore   = memWeCount;
        idleRun    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            hist[cyc % 4] = req;
            if (ack != '0) begin
                expW = (cyc >= 2) ? rrExpect(hist[(cyc + 2) % 4], modelPtr) : -1;
                if (expW < 0) begin
                    checkOutput("rndSpurious", 32'(ack), 32'd0);
                end else begin
                    checkOutput("rndAck", 32'(ack), 32'(1 << expW));
                    if (pendWe[expW]) begin
                        refMem[11'(pendAddr[expW])] = pendData[expW];
                        writesExp++;
                    end else begin
                        modelRdata = refMem[11'(pendAddr[expW])];
                    end
                    checkOutput("rndRdata", 32'(rdata), 32'(modelRdata));
                    checkOutput("rndGap", 32'(cyc - lastAckCyc >= 4), 32'd1);
                    lastAckCyc       = cyc;
                    modelPtr         = (expW + 1) % N;
                    req[expW]        = 1'b0;
                    cool[expW]       = $urandom_range(0, 3);
                    remaining[expW]  = remaining[expW] - 1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && remaining[i] > 0) begin
                    if (cool[i] == 0) begin
                        pendWe[i]   = 1'($urandom_range(0, 1));
                        pendAddr[i] = ($urandom_range(0, 15) == 0) ? 16'd1024 : 16'(16 + $urandom_range(0, 15));
                        pendData[i] = 16'($urandom);
                        applyStimulus(i, pendWe[i], pendAddr[i], pendData[i]);
                    end else begin
                        cool[i] = cool[i] - 1;
                    end
                end
            end
            idleRun = (req == '0 && !busy) ? idleRun + 1 : 0;
            if (idleRun > 4) break;
        end
        for (int i = 0; i < N; i++) checkOutput($sformatf("rndDone%0d", i), 32'(remaining[i]), 32'd0);
        checkOutput("rndWrites", 32'(memWeCount - weBefore), 32'(writesExp));
        checkOutput("rndIdleBusy", 32'(busy), 32'd0);

        // Winner drops its request mid-access
        applyStimulus(3, 1'b0, 16'd9, 16'h0);
        @(posedge clk);
        #1 req[3] = 1'b0;
        waitAck(a, lat);
        checkOutput("dropAck", 32'(a), 32'b1000);
        checkOutput("dropData", 32'(rdata), 32'(initVal(9)));
        repeat (3) @(posedge clk);

`ifdef DRAM_ARB_BOUNDS_CHECK_EN
        weBefore = memWeCount;
        applyStimulus(1, 1'b1, 16'd2000, 16'hBEEF);
        waitAck(a, lat);
        req[1] = 1'b0;
        checkOutput("oobAck", 32'(a), 32'b0010);
        checkOutput("oobErr", 32'(err), 32'd1);
        checkOutput("oobRdata", 32'(rdata), 32'hDEAD);
        checkOutput("oobNoWrite", 32'(memWeCount - weBefore), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("oobErrPulse", 32'(err), 32'd0);
`else
        checkOutput("errNeverSet", 32'(errCount), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter that shares the single-port, 16-bit shared DRAM between `NUM_CORES` core-side requesters. Each core presents a held read/write request; the arbiter selects one, drives the DRAM port for a single access, captures read data one cycle later, and returns a one-cycle acknowledge. It sits between the core load/store units and the DRAM instance, and it is the only driver of the DRAM port.

## Interface
- `NUM_CORES`, 4: number of requesters; legal range is 2 to 8.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_DEPTH`, 1025: number of DRAM words; valid addresses are 0 to 1024.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_CORES  per-core request; held high until the matching `ack`.
- `we`  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- `addr`  in  NUM_CORES*ADDR_W  flattened per-core addresses; core i uses slice [i*ADDR_W +: ADDR_W].
- `wdata`  in  NUM_CORES*DATA_W  flattened per-core write data.
- `ack`  out  NUM_CORES  one-hot, one-cycle completion pulse.
- `rdata`  out  DATA_W  read data, broadcast to all cores and valid while `ack` is high.
- `err`  out  1  out-of-range pulse, coincident with `ack`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `mem_we`  out  1  to DRAM `write_en`.
- `mem_addr`  out  ADDR_W  to DRAM `addr`.
- `mem_wdata`  out  DATA_W  to DRAM `data_in`.
- `mem_rdata`  in  DATA_W  from DRAM `data_out`; the DRAM registers it one edge after the address is presented with `mem_we`=0.

## Operation
- FSM states:
  - IDLE → ACCESS when any `req` bit is high.
  - ACCESS → CAPTURE unconditionally.
  - CAPTURE → DONE unconditionally.
  - DONE → IDLE unconditionally.
- IDLE:
  - Picks the winner: the first set `req` bit searching from `ptr` upward, wrapping from NUM_CORES-1 to 0.
  - Latches the winner index, its `we`, `addr` and `wdata` on the leaving edge.
- ACCESS:
  - `mem_addr` and `mem_wdata` carry the latched values.
  - `mem_we` equals the latched `we`.
  - `mem_we` is 0 in every other state, so the DRAM only performs reads outside ACCESS.
- CAPTURE:
  - `mem_rdata` holds the read result.
  - On the leaving edge: `ack[winner]`<=1; `rdata`<=`mem_rdata` for reads; `rdata` holds its previous value for writes.
  - Same edge: `ptr` <= winner+1, wrapping to 0 after NUM_CORES-1.
- DONE:
  - `ack` is high for exactly this cycle.
  - The requester must sample `ack` and drop or replace `req` before the DONE→IDLE edge.
- `mem_addr` and `mem_wdata` hold the last latched values outside ACCESS; they do not return to 0.
- Non-winning requests are ignored until the next IDLE; no request is ever lost while its `req` is held.
- If the winner drops `req` mid-access, the access still completes and `ack` still pulses.
- Reset values: state IDLE, `ptr`=0, `ack`=0, `err`=0, `busy`=0, `rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation: `mem_we` drops asynchronously, so no partial write reaches the DRAM. The in-flight access is discarded with no `ack`. Arbitration restarts from `ptr`=0.

## Timing
- Request sampled at edge E0.
- DRAM operates at E1.
- `ack` and `rdata` are registered at E2 and visible during cycle E2–E3.
- Next grant earliest at E4, giving a throughput of one access per 4 cycles.
- Worst-case wait for a held request is 4*(NUM_CORES-1) cycles after the current access completes.
- All outputs are registered except `busy`, which is decoded from the state register.

## Configuration
- `DRAM_ARB_BOUNDS_CHECK_EN` defined:
  - A latched address ≥ MEM_DEPTH forces `mem_we`=0 in ACCESS.
  - `rdata` returns ERR_DATA (16'hDEAD).
  - `err` pulses together with `ack`.
  - The normal 4-cycle sequence is kept.
- Not defined:
  - `err` is tied to 0.
  - Every address is passed unchanged to the DRAM.

## Structure
- Package `dram_arb_pkg` holds:
  - the state enum typedef (IDLE, ACCESS, CAPTURE, DONE);
  - the ERR_DATA constant;
  - the default MEM_DEPTH.
- Sub-module `rr_picker`: combinational; inputs `req` and `ptr`; outputs winner index and a found flag. Instantiated once.

## Test plan
- Reset: `rst_n` low → all outputs 0, `busy`=0; release with no `req` → state stays IDLE and `mem_we` stays 0.
- Single read: core 2 reads addr 5 → `ack`=4'b0100 during E2–E3, `rdata`=23, `mem_we` never high.
- Write then read: core 0 writes 16'h1234 to addr 100, then reads addr 100 → `mem_we` high for exactly one cycle; read returns 16'h1234.
- Fairness: all four `req` bits held continuously → ack order 0,1,2,3,0; each `ack` 4 cycles apart.
- Reset during ACCESS of a write to addr 7 → no `ack`; addr 7 still reads 143 after reset.
- With `DRAM_ARB_BOUNDS_CHECK_EN`: write to addr 2000 → `mem_we` stays 0, `err`=1 with `ack`, `rdata`=16'hDEAD.
